vout_timing_ctrl: RTL



---
 rtl/vout_pkg.sv | 30 +++
 rtl/vout_timing_ctrl_if.sv | 22 ++
 rtl/vout_timing_ctrl_cfg_bank.sv | 137 +++++++++++++
 rtl/vout_timing_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vout_pkg.sv
// Shared types and constants for the video output timing controller:
// FSM state encoding, configuration field addresses and default field widths.
package vout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_HFP     = 3'd0;
    localparam logic [2:0] ADDR_HSW     = 3'd1;
    localparam logic [2:0] ADDR_HBP     = 3'd2;
    localparam logic [2:0] ADDR_HACTIVE = 3'd3;
    localparam logic [2:0] ADDR_VFP     = 3'd4;
    localparam logic [2:0] ADDR_VSW     = 3'd5;
    localparam logic [2:0] ADDR_VBP     = 3'd6;
    localparam logic [2:0] ADDR_VACTIVE = 3'd7;

    localparam int DEF_HFP_WIDTH     = 8;
    localparam int DEF_HSW_WIDTH     = 4;
    localparam int DEF_HBP_WIDTH     = 8;
    localparam int DEF_HACTIVE_WIDTH = 16;
    localparam int DEF_VFP_WIDTH     = 8;
    localparam int DEF_VSW_WIDTH     = 4;
    localparam int DEF_VBP_WIDTH     = 8;
    localparam int DEF_VACTIVE_WIDTH = 16;

endpackage

// File: rtl/vout_timing_ctrl_if.sv
// Configuration write channel. A write transfers on a rising edge where
// cfg_valid_i and cfg_ready_o are both high; cfg_addr_i/cfg_wdata_i must be stable while cfg_valid_i is high.
interface vout_timing_ctrl_if;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [2:0]  cfg_addr_i;
    logic [15:0] cfg_wdata_i;

    modport master (
        output cfg_valid_i,
        output cfg_addr_i,
        output cfg_wdata_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_addr_i,
        input  cfg_wdata_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/vout_timing_ctrl_cfg_bank.sv
// Shadow/active register bank: writes land in the shadow bank, copy_en
// transfers the whole shadow bank into the active bank in one edge.
module vout_cfg_bank
    import vout_pkg::*;
#(
    parameter int HFP_WIDTH     = DEF_HFP_WIDTH,
    parameter int HSW_WIDTH     = DEF_HSW_WIDTH,
    parameter int HBP_WIDTH     = DEF_HBP_WIDTH,
    parameter int HACTIVE_WIDTH = DEF_HACTIVE_WIDTH,
    parameter int VFP_WIDTH     = DEF_VFP_WIDTH,
    parameter int VSW_WIDTH     = DEF_VSW_WIDTH,
    parameter int VBP_WIDTH     = DEF_VBP_WIDTH,
    parameter int VACTIVE_WIDTH = DEF_VACTIVE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [2:0]               wr_addr,
    input  logic [15:0]              wr_data,
    input  logic                     copy_en,
    output logic                     shadow_ok,
    output logic [HFP_WIDTH-1:0]     hfp_o,
    output logic [HSW_WIDTH-1:0]     hsw_o,
    output logic [HBP_WIDTH-1:0]     hbp_o,
    output logic [HACTIVE_WIDTH-1:0] hactive_o,
    output logic [VFP_WIDTH-1:0]     vfp_o,
    output logic [VSW_WIDTH-1:0]     vsw_o,
    output logic [VBP_WIDTH-1:0]     vbp_o,
    output logic [VACTIVE_WIDTH-1:0] vactive_o
);

    logic [HFP_WIDTH-1:0]     sh_hfp_q, sh_hfp_d, act_hfp_q, act_hfp_d;
    logic [HSW_WIDTH-1:0]     sh_hsw_q, sh_hsw_d, act_hsw_q, act_hsw_d;
    logic [HBP_WIDTH-1:0]     sh_hbp_q, sh_hbp_d, act_hbp_q, act_hbp_d;
    logic [HACTIVE_WIDTH-1:0] sh_hact_q, sh_hact_d, act_hact_q, act_hact_d;
    logic [VFP_WIDTH-1:0]     sh_vfp_q, sh_vfp_d, act_vfp_q, act_vfp_d;
    logic [VSW_WIDTH-1:0]     sh_vsw_q, sh_vsw_d, act_vsw_q, act_vsw_d;
    logic [VBP_WIDTH-1:0]     sh_vbp_q, sh_vbp_d, act_vbp_q, act_vbp_d;
    logic [VACTIVE_WIDTH-1:0] sh_vact_q, sh_vact_d, act_vact_q, act_vact_d;

    // Fields narrower than the bus keep only the low bits of the write data.
    always_comb begin
        sh_hfp_d  = sh_hfp_q;
        sh_hsw_d  = sh_hsw_q;
        sh_hbp_d  = sh_hbp_q;
        sh_hact_d = sh_hact_q;
        sh_vfp_d  = sh_vfp_q;
        sh_vsw_d  = sh_vsw_q;
        sh_vbp_d  = sh_vbp_q;
        sh_vact_d = sh_vact_q;
        if (wr_en) begin
            case (wr_addr)
                ADDR_HFP:     sh_hfp_d  = wr_data[HFP_WIDTH-1:0];
                ADDR_HSW:     sh_hsw_d  = wr_data[HSW_WIDTH-1:0];
                ADDR_HBP:     sh_hbp_d  = wr_data[HBP_WIDTH-1:0];
                ADDR_HACTIVE: sh_hact_d = wr_data[HACTIVE_WIDTH-1:0];
                ADDR_VFP:     sh_vfp_d  = wr_data[VFP_WIDTH-1:0];
                ADDR_VSW:     sh_vsw_d  = wr_data[VSW_WIDTH-1:0];
                ADDR_VBP:     sh_vbp_d  = wr_data[VBP_WIDTH-1:0];
                ADDR_VACTIVE: sh_vact_d = wr_data[VACTIVE_WIDTH-1:0];
                default:      ;
            endcase
        end
    end

    always_comb begin
        act_hfp_d  = act_hfp_q;
        act_hsw_d  = act_hsw_q;
        act_hbp_d  = act_hbp_q;
        act_hact_d = act_hact_q;
        act_vfp_d  = act_vfp_q;
        act_vsw_d  = act_vsw_q;
        act_vbp_d  = act_vbp_q;
        act_vact_d = act_vact_q;
        if (copy_en) begin
            act_hfp_d  = sh_hfp_q;
            act_hsw_d  = sh_hsw_q;
            act_hbp_d  = sh_hbp_q;
            act_hact_d = sh_hact_q;
            act_vfp_d  = sh_vfp_q;
            act_vsw_d  = sh_vsw_q;
            act_vbp_d  = sh_vbp_q;
            act_vact_d = sh_vact_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_hfp_q   <= '0;
            sh_hsw_q   <= '0;
            sh_hbp_q   <= '0;
            sh_hact_q  <= '0;
            sh_vfp_q   <= '0;
            sh_vsw_q   <= '0;
            sh_vbp_q   <= '0;
            sh_vact_q  <= '0;
            act_hfp_q  <= '0;
            act_hsw_q  <= '0;
            act_hbp_q  <= '0;
            act_hact_q <= '0;
            act_vfp_q  <= '0;
            act_vsw_q  <= '0;
            act_vbp_q  <= '0;
            act_vact_q <= '0;
        end else begin
            sh_hfp_q   <= sh_hfp_d;
            sh_hsw_q   <= sh_hsw_d;
            sh_hbp_q   <= sh_hbp_d;
            sh_hact_q  <= sh_hact_d;
            sh_vfp_q   <= sh_vfp_d;
            sh_vsw_q   <= sh_vsw_d;
            sh_vbp_q   <= sh_vbp_d;
            sh_vact_q  <= sh_vact_d;
            act_hfp_q  <= act_hfp_d;
            act_hsw_q  <= act_hsw_d;
            act_hbp_q  <= act_hbp_d;
            act_hact_q <= act_hact_d;
            act_vfp_q  <= act_vfp_d;
            act_vsw_q  <= act_vsw_d;
            act_vbp_q  <= act_vbp_d;
            act_vact_q <= act_vact_d;
        end
    end

    // Zero sync widths or active sizes would stall the generator.
    assign shadow_ok = (|sh_hsw_q) && (|sh_hact_q) && (|sh_vsw_q) && (|sh_vact_q);

    assign hfp_o     = act_hfp_q;
    assign hsw_o     = act_hsw_q;
    assign hbp_o     = act_hbp_q;
    assign hactive_o = act_hact_q;
    assign vfp_o     = act_vfp_q;
    assign vsw_o     = act_vsw_q;
    assign vbp_o     = act_vbp_q;
    assign vactive_o = act_vact_q;

endmodule

// File: rtl/vout_timing_ctrl.sv
// Video output timing controller: holds the generator's timing fields and
// applies new configurations only at frame boundaries while output runs.
module vout_timing_ctrl
    import vout_pkg::*;
#(
    parameter int HFP_WIDTH     = DEF_HFP_WIDTH,
    parameter int HSW_WIDTH     = DEF_HSW_WIDTH,
    parameter int HBP_WIDTH     = DEF_HBP_WIDTH,
    parameter int HACTIVE_WIDTH = DEF_HACTIVE_WIDTH,
    parameter int VFP_WIDTH     = DEF_VFP_WIDTH,
    parameter int VSW_WIDTH     = DEF_VSW_WIDTH,
    parameter int VBP_WIDTH     = DEF_VBP_WIDTH,
    parameter int VACTIVE_WIDTH = DEF_VACTIVE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    vout_timing_ctrl_if.slave        cfg,
    input  logic                     commit_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     frame_end_i,
    output logic [HFP_WIDTH-1:0]     hfp_o,
    output logic [HSW_WIDTH-1:0]     hsw_o,
    output logic [HBP_WIDTH-1:0]     hbp_o,
    output logic [HACTIVE_WIDTH-1:0] hactive_o,
    output logic [VFP_WIDTH-1:0]     vfp_o,
    output logic [VSW_WIDTH-1:0]     vsw_o,
    output logic [VBP_WIDTH-1:0]     vbp_o,
    output logic [VACTIVE_WIDTH-1:0] vactive_o,
    output logic                     sync_en_o,
    output logic                     busy_o,
    output logic                     cfg_err_o,
    output logic [15:0]              frame_cnt_o,
    output state_t                   dbg_state_o
);

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic        loaded_q, loaded_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic        copy_en;
    logic        shadow_ok;
    logic        wr_en;

    assign cfg.cfg_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign wr_en           = cfg.cfg_valid_i && cfg.cfg_ready_o;

    vout_cfg_bank #(
        .HFP_WIDTH    (HFP_WIDTH),
        .HSW_WIDTH    (HSW_WIDTH),
        .HBP_WIDTH    (HBP_WIDTH),
        .HACTIVE_WIDTH(HACTIVE_WIDTH),
        .VFP_WIDTH    (VFP_WIDTH),
        .VSW_WIDTH    (VSW_WIDTH),
        .VBP_WIDTH    (VBP_WIDTH),
        .VACTIVE_WIDTH(VACTIVE_WIDTH)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (cfg.cfg_addr_i),
        .wr_data  (cfg.cfg_wdata_i),
        .copy_en  (copy_en),
        .shadow_ok(shadow_ok),
        .hfp_o    (hfp_o),
        .hsw_o    (hsw_o),
        .hbp_o    (hbp_o),
        .hactive_o(hactive_o),
        .vfp_o    (vfp_o),
        .vsw_o    (vsw_o),
        .vbp_o    (vbp_o),
        .vactive_o(vactive_o)
    );

    // pend_q remembers an accepted commit so a stop in PENDING still applies it.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        loaded_d = loaded_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        copy_en  = 1'b0;
        if (frame_end_i && (state_q != ST_IDLE)) begin
            cnt_d = cnt_q + 16'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (commit_i) begin
                    if (shadow_ok) begin
                        copy_en  = 1'b1;
                        err_d    = 1'b0;
                        loaded_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start_i && !stop_i && loaded_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_DRAIN;
                end else if (commit_i) begin
                    if (shadow_ok) begin
                        state_d = ST_PENDING;
                        pend_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_end_i) begin
                    copy_en = 1'b1;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = stop_i ? ST_DRAIN : ST_RUN;
                end else if (stop_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frame_end_i) begin
                    if (pend_q) begin
                        copy_en = 1'b1;
                        err_d   = 1'b0;
                        pend_d  = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_en_o   = (state_q != ST_IDLE);
    assign busy_o      = (state_q == ST_PENDING) || ((state_q == ST_DRAIN) && pend_q);
    assign cfg_err_o   = err_q;
    assign frame_cnt_o = cnt_q;
    assign dbg_state_o = state_q;

endmodule
